// File: rtl/math_equation_pkg.sv
// Shared types and sizing for the equation solver: FSM state encoding and
// the divider iteration count derived from the operand width.
package math_equation_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DIV1,
      SETUP2,
      DIV2,
      DONE
   } state_e;

   // Width of num = 2q+4d, which is also the number of divider iterations.
   function automatic int calc_n(input int width);
      return 2 * width + 6;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: one quotient bit per cycle on magnitudes,
// signs restored at the output (quotient truncates to zero, remainder follows dividend).
module seq_divider #(
   parameter int DVD_W = 22,
   parameter int DVS_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [DVD_W-1:0] dividend_i,
   input  logic [DVS_W-1:0] divisor_i,
   output logic             done_o,
   output logic [DVD_W-1:0] quotient_o,
   output logic [DVS_W-1:0] remainder_o
);

   localparam int CW = $clog2(DVD_W) + 1;

   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic [DVD_W-1:0] quo_q;
   logic [DVS_W-1:0] rem_q;
   logic [DVS_W-1:0] dmag_q;
   logic             qneg_q;
   logic             rneg_q;

   logic [DVS_W:0]   shift_w;
   logic [DVS_W-1:0] diff_w;
   logic             fits_w;

   assign shift_w = {rem_q, quo_q[DVD_W-1]};
   assign fits_w  = (shift_w >= {1'b0, dmag_q});
   // When the subtraction is taken the true difference is below dmag, so the low bits suffice.
   assign diff_w  = shift_w[DVS_W-1:0] - dmag_q;

   // done_o flags the cycle whose closing edge retires the last quotient bit.
   assign done_o = busy_q && (cnt_q == CW'(DVD_W - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
      end else if (busy_q) begin
         cnt_q <= cnt_q + 1'b1;
         if (done_o) busy_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start_i) begin
         quo_q  <= dividend_i[DVD_W-1] ? -dividend_i : dividend_i;
         dmag_q <= divisor_i[DVS_W-1] ? -divisor_i : divisor_i;
         rem_q  <= '0;
         qneg_q <= dividend_i[DVD_W-1] ^ divisor_i[DVS_W-1];
         rneg_q <= dividend_i[DVD_W-1];
      end else if (busy_q) begin
         quo_q <= {quo_q[DVD_W-2:0], fits_w};
         rem_q <= fits_w ? diff_w : shift_w[DVS_W-1:0];
      end
   end

   assign quotient_o  = qneg_q ? -quo_q : quo_q;
   assign remainder_o = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/math_equation_solver.sv
// Recovers c from q = ((1+3c)(a-b) - 4d)/2 with two passes through one
// sequential divider: t = (2q+4d)/(a-b), then c = (t-1)/3.
module math_equation_solver
   import math_equation_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   d,
   input  logic [2*WIDTH+3:0] q,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [WIDTH-1:0]   c,
   output logic               err_zero,
   output logic               inexact,
   output logic               ovf
);

   localparam int N  = calc_n(WIDTH);
   localparam int DW = WIDTH + 1;

   state_e state_q, state_d;

   logic [N-1:0]  num_w;
   logic [DW-1:0] den_w;
   logic          zero_w;
   logic          accept_w;
   logic          start_w;
   logic [N-1:0]  dvd_w;
   logic [DW-1:0] dvs_w;
   logic          div_done_w;
   logic [N-1:0]  quo_w;
   logic [DW-1:0] rem_w;
   logic          err_zero_q;
   logic          inexact1_q;
   logic          result_w;

   function automatic logic fits_width(input logic [N-1:0] v);
      return v[N-1:WIDTH-1] == {(N-WIDTH+1){v[N-1]}};
   endfunction

   assign num_w    = {q[2*WIDTH+3], q, 1'b0} + {{(N-WIDTH-2){d[WIDTH-1]}}, d, 2'b00};
   assign den_w    = {a[WIDTH-1], a} - {b[WIDTH-1], b};
   assign zero_w   = (a == b);
   assign accept_w = valid_i && (state_q == IDLE);

   // The first division loads straight from the ports on the accept edge; SETUP2 reloads with t-1 and 3.
   assign start_w = (accept_w && !zero_w) || (state_q == SETUP2);
   assign dvd_w   = (state_q == SETUP2) ? quo_w - N'(1) : num_w;
   assign dvs_w   = (state_q == SETUP2) ? DW'(3) : den_w;

   seq_divider #(
      .DVD_W(N),
      .DVS_W(DW)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_w),
      .dividend_i (dvd_w),
      .divisor_i  (dvs_w),
      .done_o     (div_done_w),
      .quotient_o (quo_w),
      .remainder_o(rem_w)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         err_zero_q <= 1'b0;
         inexact1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept_w) err_zero_q <= zero_w;
         if (state_q == SETUP2) inexact1_q <= (rem_w != '0);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (valid_i) state_d = zero_w ? DONE : DIV1;
         DIV1:    if (div_done_w) state_d = SETUP2;
         SETUP2:  state_d = DIV2;
         DIV2:    if (div_done_w) state_d = DONE;
         DONE:    if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Results come straight from the idle divider while in DONE; the a==b path bypasses it.
   assign result_w = (state_q == DONE) && !err_zero_q;
   assign ready_o  = (state_q == IDLE);
   assign valid_o  = (state_q == DONE);
   assign err_zero = (state_q == DONE) && err_zero_q;
   assign c        = result_w ? quo_w[WIDTH-1:0] : '0;
   assign inexact  = result_w && (inexact1_q || (rem_w != '0));
   assign ovf      = result_w && !fits_width(quo_w);

endmodule

// File: tb/tb_math_equation_solver.sv
// Directed and randomized bench for math_equation_solver (WIDTH=8) against an
// integer-arithmetic model of the equation inversion.
module tb_math_equation_solver;

   logic        clk;
   logic        rst;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  a, b, d;
   logic [19:0] q;
   logic        valid_o;
   logic        ready_i;
   logic [7:0]  c;
   logic        err_zero, inexact, ovf;

   int checks = 0;
   int errors = 0;

   math_equation_solver #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .a       (a),
      .b       (b),
      .d       (d),
      .q       (q),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .c       (c),
      .err_zero(err_zero),
      .inexact (inexact),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input int ai, input int bi, input int di, input int qi,
                        output logic zero, output logic [7:0] ec,
                        output logic ein, output logic eov);
      longint num, den, t, u, c3;
      num = 2 * longint'(qi) + 4 * longint'(di);
      den = longint'(ai) - longint'(bi);
      zero = (den == 0);
      if (zero) begin
         ec = 8'd0; ein = 1'b0; eov = 1'b0;
      end else begin
         t   = num / den;
         u   = t - 1;
         c3  = u / 3;
         ec  = c3[7:0];
         ein = ((num % den) != 0) || ((u % 3) != 0);
         eov = (c3 > 127) || (c3 < -128);
      end
   endtask

   task automatic drive_ops(input int ai, input int bi, input int di, input int qi);
      a = ai[7:0];
      b = bi[7:0];
      d = di[7:0];
      q = qi[19:0];
   endtask

   task automatic apply(input int ai, input int bi, input int di, input int qi);
      check("ready_before_accept", 32'(ready_o), 32'd1);
      drive_ops(ai, bi, di, qi);
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (valid_o !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic check_res(input string tag, input int ai, input int bi, input int di,
                            input int qi, input int n);
      logic zero, ein, eov;
      logic [7:0] ec;
      model(ai, bi, di, qi, zero, ec, ein, eov);
      check({tag, "_latency"}, 32'(n), zero ? 32'd0 : 32'd45);
      check({tag, "_valid"}, 32'(valid_o), 32'd1);
      check({tag, "_c"}, 32'(c), 32'(ec));
      check({tag, "_err_zero"}, 32'(err_zero), 32'(zero));
      check({tag, "_inexact"}, 32'(inexact), 32'(ein));
      check({tag, "_ovf"}, 32'(ovf), 32'(eov));
   endtask

   task automatic retire();
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
      check("retire_ready", 32'(ready_o), 32'd1);
      check("retire_valid", 32'(valid_o), 32'd0);
   endtask

   task automatic full_op(input string tag, input int ai, input int bi, input int di, input int qi);
      int n;
      apply(ai, bi, di, qi);
      wait_valid(n);
      check_res(tag, ai, bi, di, qi, n);
      retire();
   endtask

   initial begin
      int n;
      int ra, rb, rd, rq;
      logic zero, ein, eov;
      logic [7:0] ec;

      rst = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      drive_ops(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 32'(ready_o), 32'd1);
      check("reset_valid", 32'(valid_o), 32'd0);
      check("reset_c", 32'(c), 32'd0);
      check("reset_flags", {29'd0, err_zero, inexact, ovf}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      full_op("basic", 6, 2, 1, 18);
      full_op("negden", -3, 5, 0, 20);
      full_op("zero", 7, 7, 0, 5);
      full_op("ovf", 1, 0, 0, 1000);

      for (int i = 0; i < 16; i++) begin
         ra = int'($urandom_range(255)) - 128;
         rb = (i % 5 == 4) ? ra : int'($urandom_range(255)) - 128;
         rd = int'($urandom_range(255)) - 128;
         rq = int'($urandom_range(20'hFFFFF)) - 524288;
         full_op("rand", ra, rb, rd, rq);
      end

      // Stall in DONE with a competing request on the inputs.
      apply(6, 2, 1, 18);
      wait_valid(n);
      check_res("hold", 6, 2, 1, 18, n);
      drive_ops(-3, 5, 0, 20);
      valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 32'(valid_o), 32'd1);
         check("hold_c", 32'(c), 32'd3);
         check("hold_ready", 32'(ready_o), 32'd0);
      end
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
      check("release_ready", 32'(ready_o), 32'd1);
      check("release_valid", 32'(valid_o), 32'd0);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      check("next_accept_ready", 32'(ready_o), 32'd0);
      wait_valid(n);
      check_res("next", -3, 5, 0, 20, n);
      retire();

      // Abort in the middle of the first division.
      apply(1, 0, 0, 1000);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      check("abort_ready", 32'(ready_o), 32'd1);
      check("abort_valid", 32'(valid_o), 32'd0);
      check("abort_c", 32'(c), 32'd0);
      check("abort_flags", {29'd0, err_zero, inexact, ovf}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      full_op("after_abort", 6, 2, 1, 18);

      model(1, 0, 0, 1000, zero, ec, ein, eov);
      full_op("ovf_again", 1, 0, 0, 1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/math_equation_solver.md
MATH_EQUATION_SOLVER -- requirements
Module: math_equation_solver

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width of a, b, d and c.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port valid_i, input, 1 bit: the input operands are valid.
REQ-005 The module SHALL have port ready_o, output, 1 bit: the solver accepts a new operand set.
REQ-006 The module SHALL have ports a, b and d, input, each signed WIDTH bits: the equation operands.
REQ-007 The module SHALL have port q, input, signed 2*WIDTH+4 bits: the equation result to invert.
REQ-008 The module SHALL have port valid_o, output, 1 bit: c and the flags are valid.
REQ-009 The module SHALL have port ready_i, input, 1 bit: the downstream consumer accepts the result.
REQ-010 The module SHALL have port c, output, signed WIDTH bits: the recovered operand.
REQ-011 The module SHALL have ports err_zero, inexact and ovf, output, each 1 bit: a==b; a nonzero remainder occurred; c is out of range.

Function
REQ-012 The solver SHALL invert q = ((1+3c)*(a-b) - 4d)/2: num = 2q+4d (2*WIDTH+6 bits), den = a-b (WIDTH+1 bits), t = num/den, c = (t-1)/3.
REQ-013 All divisions SHALL be signed and truncate toward zero, with the remainder taking the sign of the dividend.
REQ-014 Accept SHALL occur on a rising edge with valid_i=1 and ready_o=1; operands are registered at that edge (E0).
REQ-015 ready_o SHALL be 1 only in state IDLE.
REQ-016 The FSM states SHALL be IDLE, DIV1, SETUP2, DIV2 and DONE.
REQ-017 IDLE SHALL go to DIV1 on accept, or to DONE on accept when a==b.
REQ-018 DIV1 SHALL last N = 2*WIDTH+6 cycles, producing one quotient bit per cycle, then go to SETUP2.
REQ-019 SETUP2 SHALL last 1 cycle, loading dividend t-1 and divisor 3, then go to DIV2.
REQ-020 DIV2 SHALL last N cycles, then go to DONE.
REQ-021 DONE SHALL hold valid_o=1 with c and the flags stable until ready_i=1, then go to IDLE on that edge.
REQ-022 Latency SHALL be fixed: valid_o rises after edge E(2N+1), i.e. 45 edges after E0 for WIDTH=8; for the a==b case it rises after E0.
REQ-023 In the a==b case, err_zero=1, c=0, inexact=0 and ovf=0.
REQ-024 inexact SHALL be 1 if either remainder is nonzero.
REQ-025 ovf SHALL be 1 if (t-1)/3 does not fit in signed WIDTH bits; c then holds the low WIDTH bits.
REQ-026 valid_i while ready_o=0 SHALL be ignored; operands are not captured.
REQ-027 ready_i while valid_o=0 SHALL have no effect.
REQ-028 With valid_i=1 held in DONE while ready_i=1, the next accept SHALL occur on the following edge from IDLE, not the same edge.

Reset
REQ-029 When rst=0, the FSM SHALL go to IDLE immediately and asynchronously, regardless of clock.
REQ-030 During reset, valid_o=0, c=0, err_zero=0, inexact=0, ovf=0 and ready_o=1.
REQ-031 Reset mid-operation (DIV1, SETUP2, DIV2 or DONE) SHALL abort the operation with no valid_o pulse.
REQ-032 Divider datapath registers SHALL need no reset values.

Structure
REQ-033 The state enum type and the constant function computing N from WIDTH SHALL live in the shared package math_equation_pkg.
REQ-034 The division SHALL be one sub-module, seq_divider: a sequential signed restoring divider, parameterised on dividend and divisor widths, with start/done and quotient/remainder outputs, instantiated once and reused for both divisions.

Verification
REQ-035 (WIDTH=8) a=6, b=2, d=1, q=18 -> after 45 edges, valid_o=1, c=3, inexact=0, ovf=0, err_zero=0.
REQ-036 a=-3, b=5, d=0, q=20 -> c=-2, inexact=0 (negative divisor path).
REQ-037 a=7, b=7, q=5 -> valid_o after 1 edge, err_zero=1, c=0.
REQ-038 a=1, b=0, d=0, q=1000 -> ovf=1, inexact=1 (t=2000, 1999/3=666 rem 1).
REQ-039 Hold ready_i=0 for 10 cycles in DONE -> valid_o and c stable; ready_o=0; a new valid_i is ignored; after ready_i=1, ready_o=1 on the next cycle.
REQ-040 Assert rst=0 at cycle 20 of DIV1, then release and accept a=6, b=2, d=1, q=18 -> no stale valid_o, and the result is c=3.
